conv_window_sequencer: RTL and testbench

Initiator side of the processing-unit MAC protocol. Walks a stride-1, valid-mode 3x3 window across an IMG_W x IMG_H 8-bit image held in a synchronous-read image buffer. For each window it streams the 9 pixel/weight pairs into `processing_unit` and collects the 16-bit result it returns. Sits between the image buffer / weight loader and one `processing_unit` instance, and emits one result per window in raster order.

---
 rtl/cnn_pkg.sv | 9 +
 rtl/conv_window_sequencer_if.sv | 29 ++
 rtl/window_addr_gen.sv | 77 +++++++
 rtl/conv_window_sequencer.sv | 130 +++++++++++++
 tb/tb_conv_window_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the convolution window sequencer.
package cnn_pkg;
  localparam int KERNEL = 3;
  localparam int TAPS   = 9;
  localparam int PIX_W  = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;
endpackage

// File: rtl/conv_window_sequencer_if.sv
// Bundles the frame-control, weight-load, image-buffer, PU and result signals.
interface conv_window_sequencer_if #(parameter int ADDR_W = 6);
  logic                        start;
  logic                        wt_wr_en;
  logic [3:0]                  wt_addr;
  logic [cnn_pkg::PIX_W-1:0]   wt_data;
  logic [ADDR_W-1:0]           img_addr;
  logic [cnn_pkg::PIX_W-1:0]   img_data;
  logic                        start_pu;
  logic [cnn_pkg::PIX_W-1:0]   pixel_out;
  logic [cnn_pkg::PIX_W-1:0]   weight_out;
  logic [cnn_pkg::ACC_W-1:0]   result_in;
  logic                        done_pu_in;
  logic                        out_valid;
  logic [cnn_pkg::ACC_W-1:0]   out_data;
  logic [ADDR_W-1:0]           out_idx;
  logic                        busy;
  logic                        done;

  modport master (
    output start, wt_wr_en, wt_addr, wt_data, img_data, result_in, done_pu_in,
    input  img_addr, start_pu, pixel_out, weight_out, out_valid, out_data, out_idx, busy, done
  );

  modport slave (
    input  start, wt_wr_en, wt_addr, wt_data, img_data, result_in, done_pu_in,
    output img_addr, start_pu, pixel_out, weight_out, out_valid, out_data, out_idx, busy, done
  );
endinterface

// File: rtl/window_addr_gen.sv
// Raster walk of a stride-1 3x3 window: kx innermost, then ky, ocol, orow.
module window_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic              last_tap,
  output logic              last_window
);
  localparam logic [1:0]        K_MAX    = 2'(KERNEL - 1);
  localparam logic [ADDR_W-1:0] OCOL_MAX = ADDR_W'(IMG_W - KERNEL);
  localparam logic [ADDR_W-1:0] OROW_MAX = ADDR_W'(IMG_H - KERNEL);
  localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(IMG_W);

  logic [1:0]        kx_q, kx_d, ky_q, ky_d;
  logic [ADDR_W-1:0] ocol_q, ocol_d, orow_q, orow_d;
  logic [ADDR_W-1:0] row, col;

  always_comb begin
    last_tap    = (kx_q == K_MAX) && (ky_q == K_MAX);
    last_window = (ocol_q == OCOL_MAX) && (orow_q == OROW_MAX);
    row         = orow_q + ADDR_W'(ky_q);
    col         = ocol_q + ADDR_W'(kx_q);
    addr        = row * ROW_LEN + col;
  end

  always_comb begin
    kx_d   = kx_q;
    ky_d   = ky_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    if (clear) begin
      kx_d   = '0;
      ky_d   = '0;
      ocol_d = '0;
      orow_d = '0;
    end else if (advance) begin
      if (kx_q != K_MAX) begin
        kx_d = kx_q + 2'd1;
      end else begin
        kx_d = '0;
        if (ky_q != K_MAX) begin
          ky_d = ky_q + 2'd1;
        end else begin
          ky_d = '0;
          if (ocol_q != OCOL_MAX) begin
            ocol_d = ocol_q + 1'b1;
          end else begin
            ocol_d = '0;
            orow_d = (orow_q != OROW_MAX) ? orow_q + 1'b1 : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kx_q   <= '0;
      ky_q   <= '0;
      ocol_q <= '0;
      orow_q <= '0;
    end else begin
      kx_q   <= kx_d;
      ky_q   <= ky_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
    end
  end
endmodule

// File: rtl/conv_window_sequencer.sv
// Streams 3x3 windows of the image buffer into one processing unit and
// captures one result per window in raster order.
//   state  | meaning
//   IDLE   | waiting for start; weight file writable
//   PRIME  | issue tap 0 of window 0 to the image buffer
//   STREAM | present previous tap to PU, issue next address
//   DRAIN  | PU idle, waiting for the remaining results
module conv_window_sequencer
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6
) (
  input logic                    clk,
  input logic                    reset,
  conv_window_sequencer_if.slave bus
);
  localparam int                N      = (IMG_W - 2) * (IMG_H - 2);
  localparam logic [ADDR_W-1:0] N_CNT  = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(N - 1);
  localparam logic [3:0]        T_LAST = 4'(TAPS - 1);

  state_t             state_q, state_d;
  logic [3:0]         tap_q, tap_d;
  logic               last_issued_q, last_issued_d;
  logic [ADDR_W-1:0]  res_cnt_q, res_cnt_d;
  logic [PIX_W-1:0]   wt_q [TAPS];
  logic [PIX_W-1:0]   wt_d [TAPS];
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_idx_q, out_idx_d;
  logic               done_q, done_d;

  logic               gen_advance, gen_clear, last_tap, last_window;
  logic [ADDR_W-1:0]  gen_addr;
  logic               start_pu, accept;

  window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .advance     (gen_advance),
    .clear       (gen_clear),
    .addr        (gen_addr),
    .last_tap    (last_tap),
    .last_window (last_window)
  );

  always_comb begin
    state_d       = state_q;
    tap_d         = tap_q;
    last_issued_d = last_issued_q;
    res_cnt_d     = res_cnt_q;
    wt_d          = wt_q;
    gen_advance   = 1'b0;
    gen_clear     = 1'b0;
    start_pu      = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        gen_clear = 1'b1;
        if (bus.wt_wr_en && (bus.wt_addr <= T_LAST)) wt_d[bus.wt_addr] = bus.wt_data;
        if (bus.start) state_d = PRIME;
      end
      PRIME: begin
        gen_advance   = 1'b1;
        tap_d         = '0;
        last_issued_d = 1'b0;
        res_cnt_d     = '0;
        state_d       = STREAM;
      end
      STREAM: begin
        start_pu    = 1'b1;
        accept      = bus.done_pu_in;
        gen_advance = !last_issued_q;
        if (gen_advance && last_tap && last_window) last_issued_d = 1'b1;
        tap_d = (tap_q == T_LAST) ? 4'd0 : tap_q + 4'd1;
        // last_issued_q marks the cycle presenting the final tap of the frame
        if (last_issued_q) state_d = DRAIN;
      end
      DRAIN: begin
        accept = bus.done_pu_in;
        if (res_cnt_q == N_CNT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) res_cnt_d = res_cnt_q + 1'b1;

    out_valid_d = accept;
    out_data_d  = accept ? bus.result_in : out_data_q;
    out_idx_d   = accept ? res_cnt_q : out_idx_q;
    done_d      = accept && (res_cnt_q == N_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tap_q         <= '0;
      last_issued_q <= 1'b0;
      res_cnt_q     <= '0;
      wt_q          <= '{default: '0};
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_idx_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap_d;
      last_issued_q <= last_issued_d;
      res_cnt_q     <= res_cnt_d;
      wt_q          <= wt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_idx_q     <= out_idx_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    bus.img_addr   = gen_addr;
    bus.start_pu   = start_pu;
    bus.pixel_out  = start_pu ? bus.img_data : '0;
    bus.weight_out = start_pu ? wt_q[tap_q] : '0;
    bus.out_valid  = out_valid_q;
    bus.out_data   = out_data_q;
    bus.out_idx    = out_idx_q;
    bus.busy       = (state_q != IDLE);
    bus.done       = done_q;
  end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Frame-level bench: behavioural image RAM and MAC unit around the sequencer.
module tb_conv_window_sequencer;
  import cnn_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 6;
  localparam int N  = (W - 2) * (H - 2);

  typedef struct {
    int scen;
    int idx;
    int exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_window_sequencer_if #(.ADDR_W(AW)) bus();
  conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]  pix  [W*H];
  logic [7:0]  wexp [TAPS];
  int          cyc = 0;
  int          vecs = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.img_data <= pix[bus.img_addr];

  // MAC unit: restarts its tap count whenever start_pu is low
  logic [3:0]  pu_cnt;
  logic [15:0] pu_acc, pu_prod;
  assign pu_prod = $signed({{8{bus.pixel_out[7]}}, bus.pixel_out}) *
                   $signed({{8{bus.weight_out[7]}}, bus.weight_out});
  always @(posedge clk) begin
    if (reset) begin
      pu_cnt <= '0; pu_acc <= '0; bus.done_pu_in <= 1'b0; bus.result_in <= '0;
    end else if (!bus.start_pu) begin
      pu_cnt <= '0; pu_acc <= '0; bus.done_pu_in <= 1'b0;
    end else if (pu_cnt == 4'd8) begin
      bus.result_in <= pu_acc + pu_prod; bus.done_pu_in <= 1'b1;
      pu_cnt <= '0; pu_acc <= '0;
    end else begin
      pu_acc <= pu_acc + pu_prod; pu_cnt <= pu_cnt + 4'd1; bus.done_pu_in <= 1'b0;
    end
  end

  int          t0, mon_en;
  int          got_n, first_cyc, last_cyc, done_cyc, done_cnt, busy_fall;
  int          spu_runs, spu_len, wt_bad, idx_bad;
  logic        prev_busy, prev_spu;
  logic [15:0] got_data [N];

  initial begin
    mon_en = 0;
    forever begin
      @(negedge clk);
      if (mon_en != 0) begin
        int rel;
        rel = cyc - t0;
        if (bus.start_pu) begin
          if (!prev_spu) spu_runs++;
          if (bus.weight_out !== wexp[spu_len % 9]) wt_bad++;
          spu_len++;
        end
        if (bus.out_valid) begin
          if (got_n == 0) first_cyc = rel;
          last_cyc = rel;
          if (bus.out_idx !== AW'(got_n)) idx_bad++;
          if (got_n < N) got_data[got_n] = bus.out_data;
          got_n++;
        end
        if (bus.done) begin done_cnt++; done_cyc = rel; end
        if (prev_busy && !bus.busy) busy_fall = rel;
        prev_busy = bus.busy;
        prev_spu  = bus.start_pu;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int model(input int idx);
    int orow, ocol, acc;
    orow = idx / (W - 2);
    ocol = idx % (W - 2);
    acc  = 0;
    for (int k = 0; k < TAPS; k++)
      acc += int'($signed(pix[(orow + k / 3) * W + ocol + k % 3])) * int'($signed(wexp[k]));
    return acc & 32'hFFFF;
  endfunction

  task automatic write_wt(input int a, input logic [7:0] d);
    @(negedge clk);
    bus.wt_wr_en = 1'b1; bus.wt_addr = 4'(a); bus.wt_data = d;
    @(negedge clk);
    bus.wt_wr_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_img_addr"},   int'(bus.img_addr),   0);
    chk({tag, "_start_pu"},   int'(bus.start_pu),   0);
    chk({tag, "_pixel_out"},  int'(bus.pixel_out),  0);
    chk({tag, "_weight_out"}, int'(bus.weight_out), 0);
    chk({tag, "_out_valid"},  int'(bus.out_valid),  0);
    chk({tag, "_out_data"},   int'(bus.out_data),   0);
    chk({tag, "_out_idx"},    int'(bus.out_idx),    0);
    chk({tag, "_busy"},       int'(bus.busy),       0);
    chk({tag, "_done"},       int'(bus.done),       0);
  endtask

  task automatic begin_frame();
    got_n = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
    busy_fall = -1; spu_runs = 0; spu_len = 0; wt_bad = 0; idx_bad = 0;
    prev_busy = 1'b0; prev_spu = 1'b0;
    @(negedge clk);
    t0 = cyc; bus.start = 1'b1; mon_en = 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_frame(input int scen, input vec_t tbl[10]);
    int bad;
    begin_frame();
    for (int i = 0; i < 700 && busy_fall < 0; i++) begin
      @(negedge clk);
      if (scen == 4) begin
        bus.start    = ((cyc - t0) == 50);
        bus.wt_wr_en = ((cyc - t0) == 60);
        bus.wt_addr  = 4'd4;
        bus.wt_data  = 8'd5;
      end
    end
    bus.start = 1'b0; bus.wt_wr_en = 1'b0;
    mon_en = 0;
    if (busy_fall < 0) begin
      vecs++; miscompares++;
      $display("FAIL frame%0d_timeout: busy still high, expected fall at 328", scen);
    end
    chk("spu_runs",    spu_runs,  1);
    chk("spu_len",     spu_len,   9 * N);
    chk("weight_taps", wt_bad,    0);
    chk("result_cnt",  got_n,     N);
    chk("idx_order",   idx_bad,   0);
    chk("first_valid", first_cyc, 12);
    chk("last_valid",  last_cyc,  3 + 9 * N);
    chk("done_cyc",    done_cyc,  3 + 9 * N);
    chk("done_cnt",    done_cnt,  1);
    chk("busy_fall",   busy_fall, 4 + 9 * N);
    bad = 0;
    for (int i = 0; i < N; i++)
      if (int'(got_data[i]) !== model(i)) bad++;
    chk("model_results", bad, 0);
    for (int v = 0; v < 10; v++)
      if (tbl[v].scen == scen)
        chk($sformatf("s%0d_idx%0d", scen, tbl[v].idx), int'(got_data[tbl[v].idx]), tbl[v].exp);
  endtask

  initial begin
    vec_t tbl [10];
    tbl[0] = '{1, 0, 9};      tbl[1] = '{1, 35, 9};
    tbl[2] = '{2, 0, 9};      tbl[3] = '{2, 7, 18};
    tbl[4] = '{2, 35, 54};    tbl[5] = '{3, 0, 16384};
    tbl[6] = '{3, 35, 16384}; tbl[7] = '{4, 17, 9};
    tbl[8] = '{5, 0, 555};    tbl[9] = '{5, 35, 2580};

    reset = 1'b1; bus.start = 1'b0; bus.wt_wr_en = 1'b0;
    bus.wt_addr = '0; bus.wt_data = '0;
    for (int a = 0; a < W * H; a++) pix[a] = 8'd1;
    for (int k = 0; k < TAPS; k++) wexp[k] = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("init");

    // all ones
    for (int k = 0; k < TAPS; k++) begin wexp[k] = 8'd1; write_wt(k, 8'd1); end
    run_frame(1, tbl);

    // centre tap only; out-of-range weight addresses must be dropped
    for (int a = 0; a < W * H; a++) pix[a] = 8'(a % 128);
    for (int k = 0; k < TAPS; k++) begin
      wexp[k] = (k == 4) ? 8'd1 : 8'd0;
      write_wt(k, wexp[k]);
    end
    write_wt(9, 8'h55);
    write_wt(15, 8'h7F);
    run_frame(2, tbl);

    // most negative operands, 16-bit wrap
    for (int a = 0; a < W * H; a++) pix[a] = 8'h80;
    for (int k = 0; k < TAPS; k++) begin wexp[k] = 8'h80; write_wt(k, 8'h80); end
    run_frame(3, tbl);

    // start and weight write while busy are ignored
    for (int a = 0; a < W * H; a++) pix[a] = 8'd1;
    for (int k = 0; k < TAPS; k++) begin wexp[k] = 8'd1; write_wt(k, 8'd1); end
    run_frame(4, tbl);

    // reset mid-frame at cycle 40
    begin_frame();
    for (int i = 0; i < 100 && (cyc - t0) < 40; i++) @(negedge clk);
    mon_en = 0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    for (int k = 0; k < TAPS; k++) wexp[k] = 8'd0;
    for (int a = 0; a < W * H; a++) pix[a] = 8'(a % 128);
    for (int k = 0; k < TAPS; k++) begin wexp[k] = 8'(k + 1); write_wt(k, wexp[k]); end
    run_frame(5, tbl);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
